// File: rtl/ctrl_pkg.sv
// Shared definitions for the test-controller response path: frame constants,
// status bit positions, transmitter state encoding and the frame byte selector.
package ctrl_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN         = 5;

    // Bit positions inside the status byte carried by every frame
    localparam int STATUS_CLK_EN  = 0;
    localparam int STATUS_RST     = 1;
    localparam int STATUS_OUT_SEL = 2;
    localparam int STATUS_IN_SEL  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_ACCEPT,
        ST_WAIT_DONE
    } tx_state_t;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] status;
    } ack_t;

    // Byte idx of a frame: sync, opcode, status, seq, checksum
    function automatic logic [7:0] frame_byte(
        input logic [2:0] idx,
        input logic [7:0] sync,
        input logic [7:0] opcode,
        input logic [7:0] status,
        input logic [7:0] seq
    );
        // NOTE: the default arm gives every index a value, so no latch or X path exists.
        case (idx)
            3'd0:    frame_byte = sync;
            3'd1:    frame_byte = opcode;
            3'd2:    frame_byte = status;
            3'd3:    frame_byte = seq;
            default: frame_byte = opcode ^ status ^ seq;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_ack_fifo.sv
// Synchronous acknowledge FIFO. A push into a full FIFO is accepted when a pop
// happens in the same cycle; otherwise it is dropped and flagged on drop.
module ctrl_ack_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && !do_push;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: storage is not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ctrl_resp_tx.sv
// Response transmitter: queues acknowledge events and sends each as a 5-byte
// frame through the byte-level UART transmitter's en/busy handshake.
module ctrl_resp_tx
    import ctrl_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ack_valid,
    input  logic [7:0] ack_opcode,
    input  logic [7:0] ack_status,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    input  logic       uart_tx_busy,
    output logic       frame_busy,
    output logic       overflow,
    output logic [7:0] frames_sent
);

    tx_state_t   state;
    logic [2:0]  byte_idx;
    logic [7:0]  op_q;
    logic [7:0]  st_q;
    logic [7:0]  seq;
    logic [15:0] head_raw;
    ack_t        head;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_drop;

    assign head       = ack_t'(head_raw);
    assign fifo_pop   = (state == ST_IDLE);
    assign frame_busy = (state != ST_IDLE) || !fifo_empty;

    ctrl_ack_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ack_valid),
        .push_data ({ack_opcode, ack_status}),
        .pop       (fifo_pop),
        .pop_data  (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    // NOTE: every register here uses <= so all reads see the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            byte_idx     <= '0;
            op_q         <= '0;
            st_q         <= '0;
            seq          <= '0;
            frames_sent  <= '0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            overflow     <= 1'b0;
        end else begin
            uart_tx_en <= 1'b0;
            if (fifo_drop) overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        op_q     <= head.opcode;
                        st_q     <= head.status;
                        byte_idx <= '0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // A byte left over from before a reset may still be draining
                    if (!uart_tx_busy) begin
                        uart_tx_en   <= 1'b1;
                        uart_tx_data <= frame_byte(byte_idx, SYNC_BYTE, op_q, st_q, seq);
                        state        <= ST_WAIT_ACCEPT;
                    end
                end
                ST_WAIT_ACCEPT: begin
                    if (uart_tx_busy) state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        if (byte_idx < 3'(FRAME_LEN - 1)) begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= ST_LOAD;
                        end else begin
                            frames_sent <= frames_sent + 1'b1;
                            seq         <= seq + 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // fifo_full is only consulted inside the FIFO; kept visible for debug probes
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_ctrl_resp_tx.sv
// Directed bench for ctrl_resp_tx with a UART model busy for 10 cycles per byte.
module tb_ctrl_resp_tx;

    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ack_valid = 1'b0;
    logic [7:0] ack_opcode = 8'h00;
    logic [7:0] ack_status = 8'h00;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;
    logic       frame_busy;
    logic       overflow;
    logic [7:0] frames_sent;

    int checks = 0;
    int errors = 0;

    logic [7:0] captured[$];
    int         en_pulses = 0;
    int         en_while_busy = 0;
    int         busy_cnt = 0;
    logic       force_busy = 1'b0;

    ctrl_resp_tx #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .ack_valid    (ack_valid),
        .ack_opcode   (ack_opcode),
        .ack_status   (ack_status),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .frame_busy   (frame_busy),
        .overflow     (overflow),
        .frames_sent  (frames_sent)
    );

    always #5 clk = ~clk;

    // UART model: loads on en, stays busy for 10 cycles, ignores controller reset
    assign uart_tx_busy = (busy_cnt != 0) || force_busy;

    always @(posedge clk) begin
        if (uart_tx_en) begin
            captured.push_back(uart_tx_data);
            en_pulses <= en_pulses + 1;
            if (uart_tx_busy) en_while_busy <= en_while_busy + 1;
            busy_cnt <= 10;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    function automatic logic [7:0] exp_byte(input logic [7:0] op, input logic [7:0] st,
                                            input logic [7:0] sq, input int i);
        case (i)
            0:       return 8'hA5;
            1:       return op;
            2:       return st;
            3:       return sq;
            default: return op ^ st ^ sq;
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        ack_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        captured.delete();
    endtask

    task automatic push_ack(input logic [7:0] op, input logic [7:0] st);
        ack_valid  = 1'b1;
        ack_opcode = op;
        ack_status = st;
        @(negedge clk);
        ack_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (captured.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!frame_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (uart_tx_en !== 1'b0)      begin errors++; $display("FAIL reset_en got %b want 0", uart_tx_en); end
        checks++; if (uart_tx_data !== 8'h00)   begin errors++; $display("FAIL reset_data got %h want 00", uart_tx_data); end
        checks++; if (frame_busy !== 1'b0)      begin errors++; $display("FAIL reset_frame_busy got %b want 0", frame_busy); end
        checks++; if (overflow !== 1'b0)        begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (frames_sent !== 8'h00)    begin errors++; $display("FAIL reset_frames_sent got %h want 00", frames_sent); end
    endtask

    task automatic test_single();
        logic [7:0] exp [5] = '{8'hA5, 8'h02, 8'h03, 8'h00, 8'h01};
        int lat;
        bit ok;
        apply_reset();
        ack_valid = 1'b1; ack_opcode = 8'h02; ack_status = 8'h03;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ack_valid = 1'b0;
            lat++;
            if (uart_tx_en) break;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL single_latency got %0d want 3", lat); end
        wait_bytes(5, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d bytes want 5", captured.size()); end
        wait_idle(300, ok);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (captured[i] !== exp[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, captured[i], exp[i]); end
        end
        checks++; if (frames_sent !== 8'd1) begin errors++; $display("FAIL single_frames_sent got %0d want 1", frames_sent); end
        checks++; if (frame_busy !== 1'b0)  begin errors++; $display("FAIL single_idle got %b want 0", frame_busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [10] = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00,
                                 8'hA5, 8'h05, 8'h05, 8'h01, 8'h01};
        bit fb_low = 1'b0;
        bit ok = 1'b0;
        apply_reset();
        push_ack(8'h01, 8'h01);
        push_ack(8'h05, 8'h05);
        for (int i = 0; i < 600; i++) begin
            if (captured.size() >= 10) begin ok = 1'b1; break; end
            if (!frame_busy) fb_low = 1'b1;
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got %0d bytes want 10", captured.size()); end
        checks++; if (fb_low) begin errors++; $display("FAIL b2b_frame_busy_gap got low want high"); end
        wait_idle(300, ok);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (captured[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, captured[i], exp[i]); end
        end
        checks++; if (frames_sent !== 8'd2) begin errors++; $display("FAIL b2b_frames_sent got %0d want 2", frames_sent); end
        checks++; if (frame_busy !== 1'b0)  begin errors++; $display("FAIL b2b_idle got %b want 0", frame_busy); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] op;
        apply_reset();
        push_ack(8'h10, 8'h01);
        wait_bytes(1, 50, ok);
        for (int k = 1; k < FIFO_DEPTH + 2; k++) push_ack(8'h10 + 8'(k), 8'h01);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        wait_idle(1500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout frame_busy stuck high"); end
        checks++; if (captured.size() != 5 * (FIFO_DEPTH + 1)) begin
            errors++; $display("FAIL ovf_byte_count got %0d want %0d", captured.size(), 5 * (FIFO_DEPTH + 1));
        end
        for (int f = 0; f < FIFO_DEPTH + 1; f++) begin
            op = 8'h10 + 8'(f);
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (captured[5*f+i] !== exp_byte(op, 8'h01, 8'(f), i)) begin
                    errors++; $display("FAIL ovf_f%0d_b%0d got %h want %h", f, i, captured[5*f+i], exp_byte(op, 8'h01, 8'(f), i));
                end
            end
        end
        checks++; if (frames_sent !== 8'(FIFO_DEPTH + 1)) begin errors++; $display("FAIL ovf_frames_sent got %0d want %0d", frames_sent, FIFO_DEPTH + 1); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_push_pop_full();
        bit ok;
        apply_reset();
        push_ack(8'h20, 8'h02);
        wait_bytes(1, 50, ok);
        for (int k = 1; k <= FIFO_DEPTH; k++) push_ack(8'h20 + 8'(k), 8'h02);
        // Hold a push until the first frame ends so it lands in the pop cycle
        ack_valid = 1'b1; ack_opcode = 8'h77; ack_status = 8'h0A;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (frames_sent == 8'd1) break;
        end
        @(negedge clk);
        ack_valid = 1'b0;
        wait_idle(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ppf_timeout frame_busy stuck high"); end
        checks++; if (captured.size() != 5 * (FIFO_DEPTH + 2)) begin
            errors++; $display("FAIL ppf_byte_count got %0d want %0d", captured.size(), 5 * (FIFO_DEPTH + 2));
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (captured[5*(FIFO_DEPTH+1)+i] !== exp_byte(8'h77, 8'h0A, 8'(FIFO_DEPTH + 1), i)) begin
                errors++; $display("FAIL ppf_b%0d got %h want %h", i, captured[5*(FIFO_DEPTH+1)+i], exp_byte(8'h77, 8'h0A, 8'(FIFO_DEPTH + 1), i));
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ppf_overflow got %b want 1", overflow); end
    endtask

    task automatic test_seq_wrap();
        bit ok;
        logic [7:0] op;
        logic [7:0] st;
        apply_reset();
        for (int k = 0; k < 257; k++) begin
            captured.delete();
            op = 8'(k);
            st = 8'(k) & 8'h0F;
            push_ack(op, st);
            wait_idle(300, ok);
            if (!ok) begin
                checks++; errors++; $display("FAIL wrap_timeout frame %0d", k);
                break;
            end
            if (k >= 255) begin
                for (int i = 0; i < 5; i++) begin
                    checks++;
                    if (captured[i] !== exp_byte(op, st, 8'(k), i)) begin
                        errors++; $display("FAIL wrap_f%0d_b%0d got %h want %h", k, i, captured[i], exp_byte(op, st, 8'(k), i));
                    end
                end
            end
        end
        checks++; if (frames_sent !== 8'd1) begin errors++; $display("FAIL wrap_frames_sent got %0d want 1", frames_sent); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        apply_reset();
        push_ack(8'h40, 8'h01);
        push_ack(8'h41, 8'h02);
        push_ack(8'h42, 8'h03);
        wait_bytes(3, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout got %0d bytes want 3", captured.size()); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (uart_tx_en !== 1'b0)  begin errors++; $display("FAIL rmid_en got %b want 0", uart_tx_en); end
        checks++; if (frame_busy !== 1'b0)  begin errors++; $display("FAIL rmid_frame_busy got %b want 0", frame_busy); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL rmid_overflow got %b want 0", overflow); end
        reset = 1'b0;
        repeat (100) @(negedge clk);
        checks++; if (captured.size() != 3) begin errors++; $display("FAIL rmid_no_resume got %0d bytes want 3", captured.size()); end
        captured.delete();
        push_ack(8'h33, 8'h0C);
        wait_idle(300, ok);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (captured[i] !== exp_byte(8'h33, 8'h0C, 8'h00, i)) begin
                errors++; $display("FAIL rmid_new_b%0d got %h want %h", i, captured[i], exp_byte(8'h33, 8'h0C, 8'h00, i));
            end
        end
    endtask

    task automatic test_handshake();
        bit ok;
        int base;
        apply_reset();
        force_busy = 1'b1;
        base = en_pulses;
        push_ack(8'h55, 8'h0F);
        repeat (50) @(negedge clk);
        checks++; if (en_pulses != base) begin errors++; $display("FAIL hs_en_during_busy got %0d pulses want 0", en_pulses - base); end
        force_busy = 1'b0;
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hs_timeout frame_busy stuck high"); end
        checks++; if (en_pulses - base != 5) begin errors++; $display("FAIL hs_pulse_count got %0d want 5", en_pulses - base); end
        checks++; if (captured[0] !== 8'hA5) begin errors++; $display("FAIL hs_first_byte got %h want a5", captured[0]); end
        checks++; if (en_while_busy != 0) begin errors++; $display("FAIL hs_en_while_busy got %0d want 0", en_while_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_seq_wrap();
        test_reset_mid_frame();
        test_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
